// File: rtl/pcpi_issue_ctrl.sv
// pcpi_issue_ctrl
// Initiator side of a PCPI coprocessor link. Takes one instruction plus operands from an
// upstream valid/ready port, presents it on pcpi_* until the coprocessor completes or the
// request times out, then returns the result (or an error) on a downstream valid/ready port.
// Saturating statistics count completed and timed-out requests.
//
// Ports
//   i_clk, i_resetn                        clock (rising edge), async active-low reset
//   i_req_valid/o_req_ready                upstream request handshake
//   i_req_insn/i_req_rs1/i_req_rs2         instruction word and operands
//   o_pcpi_valid/o_pcpi_insn/rs1/rs2       request toward the coprocessor (registered)
//   i_pcpi_busy/i_pcpi_ready               coprocessor working / result pulse
//   i_pcpi_wr/i_pcpi_rd                    write-back flag and result data
//   o_rsp_valid/i_rsp_ready                downstream response handshake
//   o_rsp_data/o_rsp_wr/o_rsp_err          captured result, write-back flag, timeout flag
//   o_cnt_done/o_cnt_timeout               saturating completion / timeout counters
module pcpi_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [31:0]          i_req_insn,
    input  logic [31:0]          i_req_rs1,
    input  logic [31:0]          i_req_rs2,
    output logic                 o_pcpi_valid,
    output logic [31:0]          o_pcpi_insn,
    output logic [31:0]          o_pcpi_rs1,
    output logic [31:0]          o_pcpi_rs2,
    input  logic                 i_pcpi_busy,
    input  logic                 i_pcpi_ready,
    input  logic                 i_pcpi_wr,
    input  logic [31:0]          i_pcpi_rd,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [31:0]          o_rsp_data,
    output logic                 o_rsp_wr,
    output logic                 o_rsp_err,
    output logic [CNT_WIDTH-1:0] o_cnt_done,
    output logic [CNT_WIDTH-1:0] o_cnt_timeout
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0]      TMO_LAST = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [TmoW-1:0]      TMO_ONE  = TmoW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [TmoW-1:0]      r_tmo_cnt;
    logic [31:0]          r_pcpi_insn;
    logic [31:0]          r_pcpi_rs1;
    logic [31:0]          r_pcpi_rs2;
    logic [31:0]          r_rsp_data;
    logic                 r_rsp_wr;
    logic                 r_rsp_err;
    logic [CNT_WIDTH-1:0] r_cnt_done;
    logic [CNT_WIDTH-1:0] r_cnt_timeout;

    logic w_accept;
    logic w_done;
    logic w_timeout;

    assign w_accept  = (r_state == StIdle) && i_req_valid;
    assign w_done    = (r_state == StIssue) && i_pcpi_ready;
    // A busy cycle clears the count, so only an unbroken run of idle cycles can abort.
    // pcpi_ready in the same cycle takes priority over the abort.
    assign w_timeout = (r_state == StIssue) && !i_pcpi_ready && !i_pcpi_busy &&
                       (r_tmo_cnt == TMO_LAST);

    // State register
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_next = StIssue;
            StIssue: if (w_done || w_timeout) w_state_next = StResp;
            StResp:  if (i_rsp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Output logic. req_ready is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        o_req_ready  = 1'b0;
        o_pcpi_valid = 1'b0;
        o_rsp_valid  = 1'b0;
        unique case (r_state)
            StIdle:  o_req_ready  = i_resetn;
            StIssue: o_pcpi_valid = 1'b1;
            StResp:  o_rsp_valid  = 1'b1;
            default: o_req_ready  = 1'b0;
        endcase
    end

    // Request registers: written only on acceptance, so they stay stable through the
    // coprocessor's completion cycle.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_pcpi_insn <= '0;
            r_pcpi_rs1  <= '0;
            r_pcpi_rs2  <= '0;
        end else if (w_accept) begin
            r_pcpi_insn <= i_req_insn;
            r_pcpi_rs1  <= i_req_rs1;
            r_pcpi_rs2  <= i_req_rs2;
        end
    end

    // Timeout counter
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if (r_state == StIssue) begin
            r_tmo_cnt <= i_pcpi_busy ? '0 : r_tmo_cnt + TMO_ONE;
        end
    end

    // Response capture; held untouched in StResp until consumed.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_rsp_data <= '0;
            r_rsp_wr   <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else if (w_done) begin
            r_rsp_data <= i_pcpi_rd;
            r_rsp_wr   <= i_pcpi_wr;
            r_rsp_err  <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_wr   <= 1'b0;
            r_rsp_err  <= 1'b1;
        end
    end

    // Saturating statistics
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_cnt_done    <= '0;
            r_cnt_timeout <= '0;
        end else begin
            if (w_done && (r_cnt_done != '1)) begin
                r_cnt_done <= r_cnt_done + CNT_ONE;
            end
            if (w_timeout && (r_cnt_timeout != '1)) begin
                r_cnt_timeout <= r_cnt_timeout + CNT_ONE;
            end
        end
    end

    assign o_pcpi_insn   = r_pcpi_insn;
    assign o_pcpi_rs1    = r_pcpi_rs1;
    assign o_pcpi_rs2    = r_pcpi_rs2;
    assign o_rsp_data    = r_rsp_data;
    assign o_rsp_wr      = r_rsp_wr;
    assign o_rsp_err     = r_rsp_err;
    assign o_cnt_done    = r_cnt_done;
    assign o_cnt_timeout = r_cnt_timeout;

endmodule
